// File: rtl/slice_gather_if.sv
// Slice input and assembled-word output channels of slice_gather.
interface slice_gather_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_lane;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [40:0] out_data;
    logic [3:0]  out_miss;
    logic        out_tmo;

    // Producer of slices / consumer of words.
    modport master (
        output in_valid, in_lane, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_miss, out_tmo
    );

    // The reassembly stage itself.
    modport slave (
        input  in_valid, in_lane, in_data, out_ready,
        output in_ready, out_valid, out_data, out_miss, out_tmo
    );
endinterface

// File: rtl/slice_gather.sv
// Gathers three 12-bit slices and one 5-bit tail slice into a 41-bit word.
// Missing lanes are filled with FILL_BIT and flagged; a timer bounds the
// collection phase. The output register lets one word wait in FULL while
// the previous one is stalled downstream.
module slice_gather #(
    parameter logic FILL_BIT = 1'b0,
    parameter int   TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    lane_en,
    slice_gather_if.slave bus,
    output logic          err
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] FULL     = 2'd2;
    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_reg, state_next;
    logic [3:0]  mask_reg, rcvd_reg, rcvd_next, new_bit;
    logic [40:0] asm_reg, asm_next;
    logic [7:0]  tmr_reg;
    logic        tmo_reg;
    logic        out_valid_reg, out_tmo_reg, err_reg;
    logic [40:0] out_data_reg;
    logic [3:0]  out_miss_reg;

    logic collect, accept, lane_ok, done, tmr_hit, xfer;

    assign collect   = (state_reg == COLLECT);
    assign accept    = collect && bus.in_valid;
    assign lane_ok   = accept && mask_reg[bus.in_lane] && !rcvd_reg[bus.in_lane];
    assign new_bit   = lane_ok ? (4'b0001 << bus.in_lane) : 4'b0000;
    assign rcvd_next = rcvd_reg | new_bit;
    assign done      = (rcvd_next == mask_reg);
    assign tmr_hit   = (tmr_reg == TMR_LAST);
    assign xfer      = (state_reg == FULL) && (!out_valid_reg || bus.out_ready);

    // Per-lane field update: a lane's field takes the slice only on the
    // cycle its first valid slice is accepted.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign asm_next[gi*12 +: 12] = new_bit[gi] ? bus.in_data
                                                       : asm_reg[gi*12 +: 12];
        end
    endgenerate
    assign asm_next[40:36] = new_bit[3] ? bus.in_data[4:0] : asm_reg[40:36];

    // Assembly FSM next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (lane_en == 4'd0) ? FULL : COLLECT;
            COLLECT: if (done || tmr_hit) state_next = FULL;
            FULL:    if (xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Assembly state, lane bookkeeping and collection timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mask_reg  <= 4'd0;
            rcvd_reg  <= 4'd0;
            asm_reg   <= {41{FILL_BIT}};
            tmr_reg   <= 8'd0;
            tmo_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                mask_reg <= lane_en;
                rcvd_reg <= 4'd0;
                asm_reg  <= {41{FILL_BIT}};
                tmr_reg  <= 8'd0;
                tmo_reg  <= 1'b0;
            end else if (collect) begin
                rcvd_reg <= rcvd_next;
                asm_reg  <= asm_next;
                if (!done) begin
                    if (tmr_hit) tmo_reg <= 1'b1;
                    else         tmr_reg <= tmr_reg + 8'd1;
                end
            end
        end
    end

    // Output register: a transfer from FULL wins over a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= 41'd0;
            out_miss_reg  <= 4'd0;
            out_tmo_reg   <= 1'b0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= asm_reg;
            out_miss_reg  <= ~rcvd_reg;
            out_tmo_reg   <= tmo_reg;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Protocol error pulse: dropped slice or start outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) err_reg <= 1'b0;
        else     err_reg <= (accept && !lane_ok) || (start && state_reg != IDLE);
    end

    assign bus.in_ready  = collect;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_miss  = out_miss_reg;
    assign bus.out_tmo   = out_tmo_reg;
    assign err           = err_reg;
endmodule

// File: tb/tb_slice_gather.sv
// Scoreboard bench for slice_gather (TIMEOUT=8, FILL_BIT=0).
module tb_slice_gather;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] lane_en = 4'd0;
    logic       err;

    always #5 clk = ~clk;

    slice_gather_if bus();

    slice_gather #(.FILL_BIT(1'b0), .TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .lane_en (lane_en),
        .bus     (bus.slave),
        .err     (err)
    );

    typedef struct packed {
        logic [40:0] d;
        logic [3:0]  m;
        logic        t;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   err_cnt = 0;
    int   err_exp = 0;
    int   last_out_cyc = 0;
    int   prev_out_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: count err pulses, pop and compare every delivered word.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                $display("[TB] cyc %0d out data=%011h miss=%h tmo=%b",
                         cyc, bus.out_data, bus.out_miss, bus.out_tmo);
                if (sbq.size() == 0) begin
                    chk("unexpected_word", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(e.d));
                    chk("out_miss", 64'(bus.out_miss), 64'(e.m));
                    chk("out_tmo",  64'(bus.out_tmo),  64'(e.t));
                end
                prev_out_cyc = last_out_cyc;
                last_out_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] en);
        start   = 1'b1;
        lane_en = en;
        tick();
        start   = 1'b0;
        $display("[TB] cyc %0d start lane_en=%b", cyc, en);
    endtask

    task automatic send(input logic [1:0] lane, input logic [11:0] data);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_lane  = lane;
        bus.in_data  = data;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("in_ready_wait", 64'd0, 64'd1);
        tick();
        bus.in_valid = 1'b0;
        $display("[TB] cyc %0d slice lane=%0d data=%03h", cyc, lane, data);
    endtask

    task automatic wait_out(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) chk("out_wait_budget", 64'd0, 64'd1);
        tick();
    endtask

    initial begin
        int s;
        bus.in_valid  = 1'b0;
        bus.in_lane   = 2'd0;
        bus.in_data   = 12'd0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_err",       64'(err),           64'd0);
        rst = 1'b0;
        tick();

        // All four lanes in order.
        do_start(4'hF);
        send(2'd0, 12'hABC);
        send(2'd1, 12'h123);
        send(2'd2, 12'h456);
        sbq.push_back('{41'h1F_456_123_ABC, 4'h0, 1'b0});
        send(2'd3, 12'h01F);
        chk("t1_valid_early", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t1_valid_lat", 64'(bus.out_valid), 64'd1);
        wait_out(10);

        // Out of order, lane 2 never sent, tail truncated to 5 bits.
        do_start(4'b1011);
        sbq.push_back('{{5'h15, 12'h000, 12'h222, 12'h111}, 4'b0100, 1'b0});
        send(2'd3, 12'hFF5);
        send(2'd0, 12'h111);
        send(2'd1, 12'h222);
        wait_out(10);

        // Timeout with only lane 0.
        do_start(4'hF);
        s = cyc;
        sbq.push_back('{{29'd0, 12'h777}, 4'b1110, 1'b1});
        send(2'd0, 12'h777);
        for (int n = 0; n < 40 && !bus.out_valid; n++) tick();
        chk("t3_tmo_lat", 64'(cyc - s), 64'd9);
        wait_out(10);

        // No lanes enabled: immediate fill word.
        sbq.push_back('{41'd0, 4'hF, 1'b0});
        do_start(4'h0);
        s = cyc;
        chk("t0_valid_early", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t0_valid_lat", 64'(bus.out_valid), 64'd1);
        chk("t0_lat", 64'(cyc - s), 64'd1);
        wait_out(10);

        // Duplicate lane and disabled lane both dropped with err.
        do_start(4'b0111);
        sbq.push_back('{{5'h00, 12'hCCC, 12'hBBB, 12'hAAA}, 4'b1000, 1'b0});
        send(2'd0, 12'hAAA);
        send(2'd1, 12'hBBB);
        send(2'd1, 12'hFFF);
        send(2'd3, 12'h01E);
        send(2'd2, 12'hCCC);
        err_exp += 2;
        wait_out(10);
        chk("t4_err_count", 64'(err_cnt), 64'(err_exp));

        // Stalled output: two words queued, start in FULL is an error.
        bus.out_ready = 1'b0;
        do_start(4'hF);
        sbq.push_back('{{5'h01, 12'h003, 12'h002, 12'h001}, 4'h0, 1'b0});
        send(2'd0, 12'h001);
        send(2'd1, 12'h002);
        send(2'd2, 12'h003);
        send(2'd3, 12'h001);
        tick();
        do_start(4'hF);
        sbq.push_back('{{5'h02, 12'h006, 12'h005, 12'h004}, 4'h0, 1'b0});
        send(2'd3, 12'h002);
        send(2'd2, 12'h006);
        send(2'd1, 12'h005);
        send(2'd0, 12'h004);
        repeat (3) tick();
        chk("t5_in_ready_full", 64'(bus.in_ready), 64'd0);
        chk("t5_valid_held", 64'(bus.out_valid), 64'd1);
        chk("t5_queued", 64'(sbq.size()), 64'd2);
        do_start(4'hF);
        err_exp += 1;
        tick();
        chk("t5_err_count", 64'(err_cnt), 64'(err_exp));
        bus.out_ready = 1'b1;
        wait_out(10);
        chk("t5_back_to_back", 64'(last_out_cyc - prev_out_cyc), 64'd1);
        repeat (2) tick();
        chk("t5_drained", 64'(bus.out_valid), 64'd0);

        // Reset mid-word discards partial data.
        do_start(4'hF);
        send(2'd0, 12'hDDD);
        send(2'd1, 12'hEEE);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_data",  64'(bus.out_data),  64'd0);
        chk("t6_rst_miss",  64'(bus.out_miss),  64'd0);
        chk("t6_rst_tmo",   64'(bus.out_tmo),   64'd0);
        chk("t6_rst_ready", 64'(bus.in_ready),  64'd0);
        chk("t6_rst_err",   64'(err),           64'd0);
        rst = 1'b0;
        tick();
        do_start(4'hF);
        sbq.push_back('{{5'h03, 12'h555, 24'h0}, 4'b0011, 1'b1});
        send(2'd2, 12'h555);
        send(2'd3, 12'h003);
        wait_out(40);

        chk("err_total", 64'(err_cnt), 64'(err_exp));
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
